// File: rtl/burst_rr_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | arb_pkg : shared types, default widths and idle fill for burst_rr_arbiter |
// | Idle fill is 'x when ARB_DONTCARE_EN is defined, otherwise 0.  Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  // One bit of the fill pattern; callers replicate it to the field width.
  function automatic logic idle_data();
`ifdef ARB_DONTCARE_EN
    return 1'bx;
`else
    return 1'b0;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/burst_rr_arbiter_rr_pick.sv
// +--------------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, first set bit at/after ptr   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               any,
  output logic [IW-1:0]      index
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [IW-1:0]        offset;
  logic [IW:0]          sum;

  // Rotating a doubled copy puts the requester at ptr in bit 0.
  assign doubled = {req, req};
  assign rotated = doubled[ptr +: NUM_REQ];

  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = IW'(k);
      end
    end
  end

  assign any   = |req;
  assign sum   = {1'b0, ptr} + {1'b0, offset};
  assign index = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ))
                                           : sum[IW-1:0];

endmodule

`default_nettype wire

// File: rtl/burst_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | burst_rr_arbiter : round-robin burst arbiter onto one registered bus     |
// | Idle out_data/out_src fill set by ARB_DONTCARE_EN.            Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module burst_rr_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  localparam int IW         = $clog2(NUM_REQ),
  localparam int CW         = $clog2(MAX_BURST + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IW-1:0]                 out_src,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy
);

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         grant;
  logic [CW-1:0]         beat_cnt;

  logic                  pick_any;
  logic [IW-1:0]         pick_idx;
  logic                  can_accept;
  logic                  xfer;
  logic                  last_now;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [DATA_WIDTH-1:0] idle_word;
  logic [IW-1:0]         idle_src;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .any   (pick_any),
    .index (pick_idx)
  );

  assign idle_word  = {DATA_WIDTH{idle_data()}};
  assign idle_src   = {IW{idle_data()}};

  // The output register is free when empty or being drained this cycle.
  assign can_accept = !out_valid || out_ready;
  assign xfer       = (state == GRANT) && req_valid[grant] && can_accept;
  assign last_now   = req_last[grant] || (beat_cnt == CW'(MAX_BURST - 1));
  assign grant_data = req_data[grant*DATA_WIDTH +: DATA_WIDTH];
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant] = can_accept;
        if (xfer && last_now) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_src   <= idle_src;
      out_data  <= idle_word;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) begin
        grant <= pick_idx;
      end
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant;
        out_last  <= last_now;
        if (last_now) begin
          beat_cnt <= '0;
          ptr      <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_src   <= idle_src;
        out_data  <= idle_word;
      end
    end
  end

endmodule

`default_nettype wire
